// File: rtl/fifo_ctrl.sv
// fifo_ctrl - sequential control stage of an 8-entry FIFO.
//
// Registers the operation state together with the head/tail pointers and the
// occupancy count produced by the external combinational address calculator.
// The next operation state is chosen from wr_en/rd_en and the occupancy the
// FIFO will have once the pending operation lands (next_data_count).
//
// Ports:
//   clk              in  1  single clock, rising edge
//   reset            in  1  asynchronous, active-high
//   wr_en / rd_en    in  1  write / read request, sampled at rising edge
//   next_head        in  3  head value from address calculator
//   next_tail        in  3  tail value from address calculator
//   next_data_count  in  4  count value from address calculator
//   clr_err          in  1  clears err_sticky (FIFO_CTRL_STICKY_ERR_EN only)
//   state            out 3  registered operation state
//   head / tail      out 3  registered read / write pointers
//   data_count       out 4  registered occupancy, 0..8
//   full / empty     out 1  data_count == 8 / data_count == 0
//   wr_ack / wr_err  out 1  state == WRITE / state == WR_ERROR
//   rd_ack / rd_err  out 1  state == READ  / state == RD_ERROR
//   err_sticky       out 1  latched error flag (FIFO_CTRL_STICKY_ERR_EN only)
//
// Optional feature macro: FIFO_CTRL_STICKY_ERR_EN adds clr_err/err_sticky.

module fifo_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [2:0] next_head,
    input  logic [2:0] next_tail,
    input  logic [3:0] next_data_count,
`ifdef FIFO_CTRL_STICKY_ERR_EN
    input  logic       clr_err,
    output logic       err_sticky,
`endif
    output logic [2:0] state,
    output logic [2:0] head,
    output logic [2:0] tail,
    output logic [3:0] data_count,
    output logic       full,
    output logic       empty,
    output logic       wr_ack,
    output logic       wr_err,
    output logic       rd_ack,
    output logic       rd_err
);

    typedef enum logic [2:0] {
        INIT     = 3'b000,
        WRITE    = 3'b001,
        READ     = 3'b010,
        WR_ERROR = 3'b101,
        RD_ERROR = 3'b110,
        NO_OP    = 3'b111
    } state_t;

    state_t     state_reg;
    logic [2:0] head_reg;
    logic [2:0] tail_reg;
    logic [3:0] count_reg;

    // The decision uses the count after the pending operation, so a request
    // issued right behind an accepted one sees the updated occupancy despite
    // the one-cycle register lag. The current state is deliberately ignored.
    function automatic state_t decide(input logic w, input logic r, input logic [3:0] nc);
        state_t s;
        s = NO_OP;
        if (w && !r)
            s = (nc == 4'd8) ? WR_ERROR : WRITE;
        else if (!w && r)
            s = (nc == 4'd0) ? RD_ERROR : READ;
        return s;
    endfunction

    state_t ns_next;
    assign ns_next = decide(wr_en, rd_en, next_data_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= INIT;
            head_reg  <= 3'd0;
            tail_reg  <= 3'd0;
            count_reg <= 4'd0;
        end else begin
            state_reg <= ns_next;
            // Pointer wrap is done by the calculator; values pass straight in.
            head_reg  <= next_head;
            tail_reg  <= next_tail;
            count_reg <= next_data_count;
        end
    end

`ifdef FIFO_CTRL_STICKY_ERR_EN
    logic sticky_reg;

    // Set has priority over clear on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sticky_reg <= 1'b0;
        else if (ns_next == WR_ERROR || ns_next == RD_ERROR)
            sticky_reg <= 1'b1;
        else if (clr_err)
            sticky_reg <= 1'b0;
    end

    assign err_sticky = sticky_reg;
`endif

    // All flags decode registered values only, so they never glitch mid-cycle.
    assign state      = state_reg;
    assign head       = head_reg;
    assign tail       = tail_reg;
    assign data_count = count_reg;
    assign full       = (count_reg == 4'd8);
    assign empty      = (count_reg == 4'd0);
    assign wr_ack     = (state_reg == WRITE);
    assign wr_err     = (state_reg == WR_ERROR);
    assign rd_ack     = (state_reg == READ);
    assign rd_err     = (state_reg == RD_ERROR);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl. The address calculator is emulated by continuous
// assignments; the reference model tracks accepted writes/reads as plain
// counters and derives every expected output from them.

module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [2:0] next_head;
    logic [2:0] next_tail;
    logic [3:0] next_data_count;
    logic [2:0] state;
    logic [2:0] head;
    logic [2:0] tail;
    logic [3:0] data_count;
    logic       full, empty, wr_ack, wr_err, rd_ack, rd_err;
`ifdef FIFO_CTRL_STICKY_ERR_EN
    logic       clr_err = 1'b0;
    logic       err_sticky;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_ctrl dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .next_head(next_head),
        .next_tail(next_tail),
        .next_data_count(next_data_count),
`ifdef FIFO_CTRL_STICKY_ERR_EN
        .clr_err(clr_err),
        .err_sticky(err_sticky),
`endif
        .state(state),
        .head(head),
        .tail(tail),
        .data_count(data_count),
        .full(full),
        .empty(empty),
        .wr_ack(wr_ack),
        .wr_err(wr_err),
        .rd_ack(rd_ack),
        .rd_err(rd_err)
    );

    // Address calculator environment: acts on the registered state.
    assign next_tail       = (state == 3'b001) ? tail + 3'd1 : tail;
    assign next_head       = (state == 3'b010) ? head + 3'd1 : head;
    assign next_data_count = (state == 3'b001) ? data_count + 4'd1 :
                             (state == 3'b010) ? data_count - 4'd1 : data_count;

    // ---------------- reference model ----------------
    // acc_w/acc_r: requests accepted so far. The registered pointers/count
    // reflect only operations accepted at earlier edges (one-edge lag).
    int         acc_w = 0, acc_r = 0;
    int         reg_w = 0, reg_r = 0;
    logic [2:0] exp_state = 3'b000;
    logic       exp_sticky = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_w = 0; acc_r = 0; reg_w = 0; reg_r = 0;
            exp_state = 3'b000;
            exp_sticky = 1'b0;
        end else begin
            int occ;
            reg_w = acc_w;
            reg_r = acc_r;
            occ = acc_w - acc_r;
            if (wr_en && !rd_en) begin
                if (occ >= 8) exp_state = 3'b101;
                else begin exp_state = 3'b001; acc_w = acc_w + 1; end
            end else if (rd_en && !wr_en) begin
                if (occ <= 0) exp_state = 3'b110;
                else begin exp_state = 3'b010; acc_r = acc_r + 1; end
            end else begin
                exp_state = 3'b111;
            end
`ifdef FIFO_CTRL_STICKY_ERR_EN
            if (exp_state == 3'b101 || exp_state == 3'b110) exp_sticky = 1'b1;
            else if (clr_err) exp_sticky = 1'b0;
`endif
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int cnt;
        cnt = reg_w - reg_r;
        chk("state", int'(state), int'(exp_state));
        chk("head", int'(head), reg_r % 8);
        chk("tail", int'(tail), reg_w % 8);
        chk("data_count", int'(data_count), cnt);
        chk("full", int'(full), int'(cnt == 8));
        chk("empty", int'(empty), int'(cnt == 0));
        chk("wr_ack", int'(wr_ack), int'(exp_state == 3'b001));
        chk("wr_err", int'(wr_err), int'(exp_state == 3'b101));
        chk("rd_ack", int'(rd_ack), int'(exp_state == 3'b010));
        chk("rd_err", int'(rd_err), int'(exp_state == 3'b110));
`ifdef FIFO_CTRL_STICKY_ERR_EN
        chk("err_sticky", int'(err_sticky), int'(exp_sticky));
`endif
        $display("cyc t=%0t wr=%0b rd=%0b state=%0d head=%0d tail=%0d cnt=%0d",
                 $time, wr_en, rd_en, state, head, tail, data_count);
    end

    // Drive one request for one edge; inputs change just after the negedge.
    task automatic cyc(input logic w, input logic r);
        @(negedge clk); #1;
        wr_en = w;
        rd_en = r;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #20;
        @(negedge clk); #1;
        reset = 1'b0;

        // Reset mid write burst: four writes leave state=WRITE, count=3.
        repeat (4) cyc(1'b1, 1'b0);
        @(negedge clk); #2;
        chk("pre_reset_count", int'(data_count), 3);
        chk("pre_reset_state", int'(state), 1);
        reset = 1'b1;
        wr_en = 1'b0;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_head", int'(head), 0);
        chk("async_tail", int'(tail), 0);
        chk("async_count", int'(data_count), 0);
        chk("async_empty", int'(empty), 1);
        chk("async_full", int'(full), 0);
        @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;

        // Nine writes from empty: eighth acked, ninth refused.
        repeat (8) cyc(1'b1, 1'b0);
        #1 chk("w8_ack", int'(wr_ack), 1);
        cyc(1'b1, 1'b0);
        #1;
        chk("w9_err", int'(wr_err), 1);
        chk("w9_count", int'(data_count), 8);
        chk("w9_full", int'(full), 1);
        chk("w9_tail", int'(tail), 0);

        // Nine reads from full.
        repeat (8) cyc(1'b0, 1'b1);
        #1 chk("r8_ack", int'(rd_ack), 1);
        cyc(1'b0, 1'b1);
        #1;
        chk("r9_err", int'(rd_err), 1);
        chk("r9_count", int'(data_count), 0);
        chk("r9_head", int'(head), 0);
        chk("r9_empty", int'(empty), 1);

        // Simultaneous request at count 4.
        repeat (4) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        #1 chk("both_state", int'(state), 7);
        cyc(1'b0, 1'b0);
        #1;
        chk("both_count", int'(data_count), 4);
        chk("both_tail", int'(tail), 4);
        chk("both_head", int'(head), 0);

        // Read from empty after reset.
        do_reset();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        #1;
        chk("rde_count", int'(data_count), 0);
`ifdef FIFO_CTRL_STICKY_ERR_EN
        chk("sticky_set", int'(err_sticky), 1);
        @(negedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        clr_err = 1'b0;
        chk("sticky_clr", int'(err_sticky), 0);
        // Set and clear on the same edge: set wins.
        rd_en = 1'b1;
        clr_err = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        rd_en = 1'b0;
        clr_err = 1'b0;
        chk("sticky_prio", int'(err_sticky), 1);
`endif

        // Alternating write/read at count 7.
        do_reset();
        repeat (7) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        #1 chk("alt_start", int'(data_count), 7);
        repeat (3) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b1);
        end
        cyc(1'b0, 1'b0);
        #1 chk("alt_end", int'(data_count), 7);

        cyc(1'b0, 1'b0);
        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, failures=%0d", failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Sequential control stage of the 8-entry FIFO. It registers the FIFO operation state and the head, tail and data_count values, and decides the next state from `wr_en`/`rd_en` and the FIFO occupancy. Its `state`, `head`, `tail` and `data_count` outputs feed the combinational address calculator. The calculator's `next_head`, `next_tail` and `next_data_count` come back here and are registered.

## Interface
- `INIT`, 3'b000, power-on/reset state
- `WRITE`, 3'b001, accepted write
- `READ`, 3'b010, accepted read
- `WR_ERROR`, 3'b101, write refused (full)
- `RD_ERROR`, 3'b110, read refused (empty)
- `NO_OP`, 3'b111, idle or simultaneous request
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `wr_en` in 1: write request, sampled at rising edge
- `rd_en` in 1: read request, sampled at rising edge
- `next_head` in 3: head value from address calculator
- `next_tail` in 3: tail value from address calculator
- `next_data_count` in 4: count value from address calculator
- `state` out 3: registered operation state
- `head` out 3: registered read pointer
- `tail` out 3: registered write pointer
- `data_count` out 4: registered occupancy, 0..8
- `full` out 1: `data_count == 8`
- `empty` out 1: `data_count == 0`
- `wr_ack` / `wr_err` out 1: `state == WRITE` / `state == WR_ERROR`
- `rd_ack` / `rd_err` out 1: `state == READ` / `state == RD_ERROR`

## Operation
- Reset asserted, at any time including mid-operation:
  - Immediate, clock-independent.
  - `state=INIT`, `head=0`, `tail=0`, `data_count=0`.
  - Outputs: `full=0`, `empty=1`, all ack/err flags 0.
- Register update, every rising edge with reset low:
  - `head←next_head`, `tail←next_tail`, `data_count←next_data_count`.
  - `state←ns`.
- Occupancy used for the next-state decision is `nc = next_data_count`, the count in force after the pending operation. This prevents back-to-back overflow or underflow caused by the one-cycle register lag.
- Next-state `ns`:
  - `wr_en=1, rd_en=0`: `WR_ERROR` if `nc==8`, else `WRITE`.
  - `wr_en=0, rd_en=1`: `RD_ERROR` if `nc==0`, else `READ`.
  - `wr_en=rd_en`, both 0 or both 1: `NO_OP`. Simultaneous requests are not serviced.
- `ns` does not depend on the current state. `INIT` is left on the first edge after reset release.
- `full`, `empty` and the ack/err flags are pure decodes of registered values; they are glitch-free relative to `clk`.
- Pointer wrap (7→0) is produced by the address calculator and registered unchanged here.
- `data_count` is never range-checked here. Correct FSM decisions guarantee it stays in 0..8.

## Timing
- Request sampled at edge E0. `state` and the ack/err flags are valid after E0.
- The calculator output for that operation is registered at E1. `head`/`tail`/`data_count`/`full`/`empty` reflect the operation after E1.
- Back-to-back writes are legal every cycle. The eighth consecutive write from empty gets `wr_ack`; the ninth gets `wr_err`.
- Back-to-back reads behave symmetrically: the read that would take count below 0 gets `rd_err`.
- Error and `NO_OP` states leave pointers and count unchanged, because the calculator passes them through.

## Configuration
- Macro `FIFO_CTRL_STICKY_ERR_EN`.
- Defined:
  - Adds input `clr_err` (1 bit) and output `err_sticky` (1 bit).
  - `err_sticky` sets on any edge where `ns` is `WR_ERROR` or `RD_ERROR`, and holds until reset or `clr_err=1` at an edge.
  - If set and clear occur on the same edge, set wins.
  - Reset value 0.
- Undefined: neither port exists, and the block behaviour is otherwise identical.

## Test plan
- Reset mid-write burst (`data_count=3`, `state=WRITE`), `reset=1` between edges -> `state=000`, `head=tail=0`, `data_count=0`, `empty=1` before the next edge.
- Nine consecutive cycles `wr_en=1` from empty -> `wr_ack` cycles 1-8, `wr_err` cycle 9; `data_count=8`, `full=1`, `tail=0` after wrap.
- From full, nine consecutive `rd_en=1` -> `rd_ack` 8 cycles then `rd_err`; `head=0`, `empty=1`, `data_count=0`.
- `wr_en=rd_en=1` at `data_count=4` -> `state=NO_OP`; head, tail and count unchanged.
- Read from empty after reset -> `state=RD_ERROR`, `data_count` stays 0. With `FIFO_CTRL_STICKY_ERR_EN`: `err_sticky=1` until `clr_err` pulse, then 0.
- Alternating write/read at `data_count=7` -> no error flags, count oscillates 8/7, `full` toggles accordingly.
